// File: rtl/rpn_pkg.sv
// Shared constants, state encoding and error-latch helper for the RPN stack evaluator.
package rpn_pkg;
  localparam int DATA_W_DEF      = 16;
  localparam int STACK_DEPTH_DEF = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_EOL = 4'd15;

  localparam logic [1:0] ERR_UNDERFLOW = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_DIV_ZERO  = 2'd2;
  localparam logic [1:0] ERR_PROTOCOL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_EMIT = 2'd3
  } rpn_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } line_err_t;

  // The first error seen in a line is the one reported.
  function automatic line_err_t latch_err(input line_err_t cur, input logic [1:0] code);
    line_err_t nxt;
    if (cur.valid) begin
      nxt = cur;
    end else begin
      nxt.valid = 1'b1;
      nxt.code  = code;
    end
    return nxt;
  endfunction
endpackage

// File: rtl/rpn_divider.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, done pulses
// DATA_W cycles after start. Divisor must be non-zero.
module rpn_divider
  import rpn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   rem_sh_s;

  // Next-state: load on start, then shift the dividend MSB into the remainder each cycle.
  always_comb begin
    rem_sh_s = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      rem_d = {(DATA_W + 1){1'b0}};
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(DATA_W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_sh_s >= {1'b0, dvs_q}) begin
        rem_d = rem_sh_s - {1'b0, dvs_q};
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_s;
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= {(DATA_W + 1){1'b0}};
      quo_q  <= {DATA_W{1'b0}};
      dvs_q  <= {DATA_W{1'b0}};
      cnt_q  <= {CW{1'b0}};
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/rpn_stack_eval.sv
// Token-driven RPN evaluator: register-array stack, one-cycle ALU ops, sequential
// divide, and a per-line result or first-error report on EOL.
module rpn_stack_eval
  import rpn_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] num,
  input  logic              num_ready,
  input  logic [3:0]        op,
  input  logic              op_ready,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              err_valid,
  output logic [1:0]        err_code
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  rpn_state_e        state_q, state_d;
  logic [DATA_W-1:0] stack_q [STACK_DEPTH];
  logic [DATA_W-1:0] stack_d [STACK_DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  line_err_t         err_q, err_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_push_q, pend_push_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [PW-1:0]     top_idx_s, below_idx_s, push_idx_s;
  logic [DATA_W-1:0] opa_s, opb_s, div_quo_s;
  logic              has_two_s, token_s, div_start_s, div_done_s;

  assign top_idx_s   = PW'(depth_q - DW'(1));
  assign below_idx_s = PW'(depth_q - DW'(2));
  assign push_idx_s  = PW'(depth_q);
  assign opb_s       = stack_q[top_idx_s];
  assign opa_s       = stack_q[below_idx_s];
  assign has_two_s   = (depth_q >= DW'(2));
  assign token_s     = num_ready | op_ready;

  rpn_divider #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (opa_s),
    .divisor  (opb_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Token acceptance, operator sequencing and line reporting.
  always_comb begin
    state_d        = state_q;
    stack_d        = stack_q;
    depth_d        = depth_q;
    err_d          = err_q;
    pend_d         = pend_q;
    pend_push_d    = pend_push_q;
    result_d       = result_q;
    err_code_d     = err_code_q;
    result_valid_d = 1'b0;
    err_valid_d    = 1'b0;
    div_start_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (num_ready) begin
          if (depth_q == DEPTH_FULL) begin
            err_d = latch_err(err_q, ERR_OVERFLOW);
          end else begin
            stack_d[push_idx_s] = num;
            depth_d = depth_q + DW'(1);
          end
          err_d = op_ready ? latch_err(err_d, ERR_PROTOCOL) : err_d;
        end else if (op_ready) begin
          case (op)
            OP_ADD, OP_SUB, OP_MUL: begin
              state_d     = ST_EXEC;
              pend_push_d = has_two_s;
              err_d       = has_two_s ? err_q : latch_err(err_q, ERR_UNDERFLOW);
              case (op)
                OP_ADD:  pend_d = opa_s + opb_s;
                OP_SUB:  pend_d = opa_s - opb_s;
                default: pend_d = opa_s * opb_s;
              endcase
            end
            OP_DIV: begin
              if (!has_two_s) begin
                state_d     = ST_EXEC;
                pend_push_d = 1'b0;
                err_d       = latch_err(err_q, ERR_UNDERFLOW);
              end else if (opb_s == {DATA_W{1'b0}}) begin
                // Divide-by-zero still consumes both operands and leaves a zero.
                state_d     = ST_EXEC;
                pend_push_d = 1'b1;
                pend_d      = {DATA_W{1'b0}};
                err_d       = latch_err(err_q, ERR_DIV_ZERO);
              end else begin
                state_d     = ST_DIV;
                div_start_s = 1'b1;
              end
            end
            OP_EOL:  state_d = ST_EMIT;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        err_d = token_s ? latch_err(err_q, ERR_PROTOCOL) : err_q;
        if (pend_push_q) begin
          stack_d[below_idx_s] = pend_q;
          depth_d = depth_q - DW'(1);
        end else begin
          depth_d = depth_q;
        end
        state_d = ST_IDLE;
      end
      ST_DIV: begin
        err_d = token_s ? latch_err(err_q, ERR_PROTOCOL) : err_q;
        if (div_done_s) begin
          stack_d[below_idx_s] = div_quo_s;
          depth_d = depth_q - DW'(1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_EMIT: begin
        if (err_q.valid) begin
          err_valid_d = 1'b1;
          err_code_d  = err_q.code;
        end else if (depth_q == DW'(1)) begin
          result_valid_d = 1'b1;
          result_d       = stack_q[0];
        end else begin
          err_valid_d = 1'b1;
          err_code_d  = (depth_q == DW'(0)) ? ERR_UNDERFLOW : ERR_PROTOCOL;
        end
        depth_d = {DW{1'b0}};
        err_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs registered; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= {DATA_W{1'b0}};
      depth_q        <= {DW{1'b0}};
      err_q          <= '0;
      pend_q         <= {DATA_W{1'b0}};
      pend_push_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= {DATA_W{1'b0}};
      result_valid_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      stack_q        <= stack_d;
      depth_q        <= depth_d;
      err_q          <= err_d;
      pend_q         <= pend_d;
      pend_push_q    <= pend_push_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
endmodule

// File: tb/tb_rpn_stack_eval.sv
// Bench for rpn_stack_eval: queue-based line model compared every cycle, directed
// lines with literal expectations, then randomized token traffic.
module tb_rpn_stack_eval;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int A_NONE = 0, A_PUSH = 1, A_EMIT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] num = '0;
  logic         num_ready = 1'b0;
  logic [3:0]   op = 4'd0;
  logic         op_ready = 1'b0;
  logic         busy, result_valid, err_valid;
  logic [W-1:0] result;
  logic [1:0]   err_code;

  rpn_stack_eval #(.DATA_W(W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .num_ready(num_ready), .op(op), .op_ready(op_ready),
    .busy(busy), .result(result), .result_valid(result_valid), .err_valid(err_valid),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue stack, a first-error slot and a busy countdown.
  logic [W-1:0] m_stk[$];
  int           m_err = -1;
  int           m_left = 0;
  int           m_act = A_NONE;
  logic [W-1:0] m_val = '0;
  logic         m_busy = 1'b0, m_rv = 1'b0, m_ev = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [1:0]   m_code = 2'd0;
  int           m_rv_cnt = 0, m_ev_cnt = 0, d_rv_cnt = 0, d_ev_cnt = 0;
  logic [W-1:0] m_last_result = '0;
  logic [1:0]   m_last_code = 2'd0;

  function automatic void note_err(input int c);
    if (m_err < 0) m_err = c;
  endfunction

  task automatic model_start(input logic [3:0] o);
    logic [W-1:0] a, b;
    if (o >= 4'd1 && o <= 4'd4) begin
      m_left = 1;
      if (m_stk.size() < 2) begin
        note_err(0);
        m_act = A_NONE;
      end else begin
        b = m_stk.pop_back();
        a = m_stk.pop_back();
        m_act = A_PUSH;
        if (o == 4'd1) m_val = a + b;
        else if (o == 4'd2) m_val = a - b;
        else if (o == 4'd3) m_val = a * b;
        else if (b == '0) begin
          note_err(2);
          m_val = '0;
        end else begin
          m_val  = a / b;
          m_left = W + 1;
        end
      end
    end else if (o == 4'd15) begin
      m_left = 1;
      m_act  = A_EMIT;
    end
  endtask

  task automatic model_finish();
    if (m_act == A_PUSH) m_stk.push_back(m_val);
    if (m_act == A_EMIT) begin
      if (m_err >= 0) begin
        m_ev = 1'b1; m_code = 2'(m_err);
      end else if (m_stk.size() == 1) begin
        m_rv = 1'b1; m_result = m_stk[0];
      end else begin
        m_ev = 1'b1; m_code = (m_stk.size() == 0) ? 2'd0 : 2'd3;
      end
      if (m_rv) begin m_rv_cnt++; m_last_result = m_result; end
      if (m_ev) begin m_ev_cnt++; m_last_code = m_code; end
      m_stk.delete();
      m_err = -1;
    end
    m_act = A_NONE;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_stk.delete(); m_err = -1; m_left = 0; m_act = A_NONE;
      m_busy = 1'b0; m_rv = 1'b0; m_ev = 1'b0; m_result = '0; m_code = 2'd0;
    end else begin
      m_rv = 1'b0; m_ev = 1'b0;
      if (m_left > 0) begin
        if ((num_ready || op_ready) && m_act != A_EMIT) note_err(3);
        m_left--;
        if (m_left == 0) model_finish();
      end else if (num_ready) begin
        if (m_stk.size() >= DEPTH) note_err(1);
        else m_stk.push_back(num);
        if (op_ready) note_err(3);
      end else if (op_ready) begin
        model_start(op);
      end
      m_busy = (m_left > 0);
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("result_valid", 32'(result_valid), 32'(m_rv));
      check("err_valid", 32'(err_valid), 32'(m_ev));
      check("result", 32'(result), 32'(m_result));
      check("err_code", 32'(err_code), 32'(m_code));
      if (result_valid) d_rv_cnt++;
      if (err_valid) d_ev_cnt++;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 100) begin k++; @(negedge clk); end
    check("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic tok_num(input logic [W-1:0] v);
    num = v; num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
  endtask

  task automatic pulse_op(input logic [3:0] o);
    op = o; op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic tok_op(input logic [3:0] o);
    pulse_op(o);
    wait_idle();
  endtask

  task automatic clear_counts();
    m_rv_cnt = 0; m_ev_cnt = 0; d_rv_cnt = 0; d_ev_cnt = 0;
  endtask

  task automatic line_check(input string tag, input int exp_rv, input int exp_ev,
                            input logic [W-1:0] exp_res, input logic [1:0] exp_code);
    wait_idle();
    @(negedge clk);
    check({tag, "_model_rv_cnt"}, 32'(m_rv_cnt), 32'(exp_rv));
    check({tag, "_dut_rv_cnt"}, 32'(d_rv_cnt), 32'(exp_rv));
    check({tag, "_model_ev_cnt"}, 32'(m_ev_cnt), 32'(exp_ev));
    check({tag, "_dut_ev_cnt"}, 32'(d_ev_cnt), 32'(exp_ev));
    if (exp_rv > 0) begin
      check({tag, "_model_result"}, 32'(m_last_result), 32'(exp_res));
      check({tag, "_dut_result"}, 32'(result), 32'(exp_res));
    end
    if (exp_ev > 0) begin
      check({tag, "_model_code"}, 32'(m_last_code), 32'(exp_code));
      check({tag, "_dut_code"}, 32'(err_code), 32'(exp_code));
    end
    clear_counts();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] op_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15};

  initial begin
    int cnt, r, sel;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_counts();

    tok_num(16'd12); tok_num(16'd12); tok_op(4'd1);
    tok_num(16'd3); tok_op(4'd3); tok_num(16'd2); tok_op(4'd4); tok_op(4'd15);
    line_check("chain36", 1, 0, 16'd36, 2'd0);
    check("chain36_busy_low", 32'(busy), 32'd0);

    tok_num(16'd5); tok_op(4'd1); tok_op(4'd15);
    line_check("underflow", 0, 1, 16'd0, 2'd0);

    tok_num(16'd7); tok_num(16'd0); tok_op(4'd4); tok_op(4'd15);
    line_check("divzero", 0, 1, 16'd0, 2'd2);
    tok_num(16'd9); tok_op(4'd15);
    line_check("after_divzero", 1, 0, 16'd9, 2'd0);

    for (int i = 0; i < 9; i++) tok_num(16'(i + 1));
    tok_op(4'd15);
    line_check("overflow", 0, 1, 16'd0, 2'd1);
    tok_num(16'd3); tok_num(16'd5); tok_op(4'd2); tok_op(4'd15);
    line_check("sub_wrap", 1, 0, 16'hFFFE, 2'd0);

    tok_num(16'd100); tok_num(16'd7);
    pulse_op(4'd4);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      num = 16'd55; num_ready = (cnt == 3);
      @(negedge clk);
    end
    num_ready = 1'b0;
    check("div_busy_cycles", 32'(cnt), 32'd17);
    tok_op(4'd15);
    line_check("busy_token", 0, 1, 16'd0, 2'd3);

    tok_op(4'd15);
    line_check("empty_eol", 0, 1, 16'd0, 2'd0);
    tok_num(16'd1); tok_num(16'd2); tok_op(4'd15);
    line_check("two_left", 0, 1, 16'd0, 2'd3);
    num = 16'd5; op = 4'd1; num_ready = 1'b1; op_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0; op_ready = 1'b0;
    tok_op(4'd15);
    line_check("both_ready", 0, 1, 16'd0, 2'd3);

    tok_num(16'd100); tok_num(16'd7); pulse_op(4'd4);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_err_valid", 32'(err_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_counts();
    tok_num(16'd4); tok_num(16'd4); tok_op(4'd3); tok_op(4'd15);
    line_check("after_reset", 1, 0, 16'd16, 2'd0);

    for (int i = 0; i < 500; i++) begin
      r   = $urandom_range(0, 9);
      sel = $urandom_range(0, 7);
      num_ready = (r >= 4 && r <= 6) || (r == 9);
      op_ready  = (r >= 7);
      num = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
      op  = (sel < 6) ? op_tab[sel] : 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    num_ready = 1'b0; op_ready = 1'b0;
    wait_idle();
    tok_op(4'd15);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_eval.md
RPN_STACK_EVAL -- requirements
Module: rpn_stack_eval

Interface
REQ-001 SHALL have parameters DATA_W, default 16, operand/result width; STACK_DEPTH, default 8, maximum stack entries.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port num  input  DATA_W  unsigned operand token from tokenizer.
REQ-005 SHALL have port num_ready  input  1  one-cycle pulse, num valid.
REQ-006 SHALL have port op  input  4  operator token code.
REQ-007 SHALL have port op_ready  input  1  one-cycle pulse, op valid.
REQ-008 SHALL have port busy  output  1  high while an operator is executing; tokens not accepted.
REQ-009 SHALL have port result  output  DATA_W  evaluated line result, held until next emit.
REQ-010 SHALL have port result_valid  output  1  one-cycle pulse, result valid, to TX formatter.
REQ-011 SHALL have port err_valid  output  1  one-cycle pulse, line failed.
REQ-012 SHALL have port err_code  output  2  0 underflow, 1 overflow, 2 divide-by-zero, 3 protocol; held until next emit.

Function
REQ-013 SHALL use op codes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 15 EOL; other codes treated as NOP.
REQ-014 SHALL push num on num_ready in IDLE; depth increments next cycle.
REQ-015 SHALL, on ADD/SUB/MUL, pop B (top) and A (below), push A op B; SUB = A-B modulo 2^DATA_W; MUL = low DATA_W bits; ADD wraps.
REQ-016 SHALL complete ADD/SUB/MUL in state EXEC, one cycle after op_ready; busy high that cycle.
REQ-017 SHALL, on DIV, compute unsigned truncated A/B in state DIV, DATA_W iterations, busy high throughout; quotient pushed DATA_W+1 cycles after op_ready.
REQ-018 SHALL, on EOL, enter EMIT; next cycle pulse result_valid with top entry if depth==1 and no line error, else pulse err_valid.
REQ-019 SHALL, after EMIT, clear stack (depth 0) and line error flag; return to IDLE.
REQ-020 SHALL state machine IDLE -> EXEC|DIV|EMIT -> IDLE; NOP causes no transition.
REQ-021 SHALL, on binary op with depth<2, leave stack unchanged, latch code 0 (first error in line wins).
REQ-022 SHALL, on push with depth==STACK_DEPTH, drop num, latch code 1.
REQ-023 SHALL, on DIV with B==0, pop both, push 0, latch code 2, skip iteration (EXEC-length latency).
REQ-024 SHALL, on num_ready and op_ready same cycle, accept num, drop op, latch code 3.
REQ-025 SHALL, on any token while busy, drop it and latch code 3.
REQ-026 SHALL, on EOL with depth!=1 and no latched error, report code 0 if depth 0, code 1... no: report code 3 if depth>1, code 0 if depth==0.

Reset
REQ-027 SHALL on rst_n low, immediately: state IDLE, depth 0, busy 0, result 0, result_valid 0, err_valid 0, err_code 0, line error clear.
REQ-028 SHALL abort an in-progress DIV on reset with no output pulse.

Structure
REQ-029 SHALL place op codes, error codes, DATA_W and STACK_DEPTH defaults in shared package rpn_pkg.
REQ-030 SHALL implement division in sub-module rpn_divider (sequential restoring, start/done handshake).
REQ-031 SHALL store stack in register array with depth pointer; no RAM macro.

Verification
REQ-032 SHALL cover: tokens 12,12,ADD,3,MUL,2,DIV,EOL -> result_valid once, result=36, busy low after.
REQ-033 SHALL cover: 5,ADD,EOL -> err_valid, err_code=0, no result_valid.
REQ-034 SHALL cover: 7,0,DIV,EOL -> err_valid, err_code=2; following line 9,EOL -> result=9.
REQ-035 SHALL cover: 9 pushes then EOL -> err_code=1; 3,5,SUB,EOL -> result=16'hFFFE.
REQ-036 SHALL cover: 100,7,DIV then num_ready 3 cycles later -> token dropped, EOL gives err_code=3; DIV latency exactly 17 cycles.
REQ-037 SHALL cover: rst_n low mid-DIV -> all outputs zero, next line 4,4,MUL,EOL -> result=16.
